// File: rtl/example2_capture_fifo_if.sv
// Capture FIFO handshake bundle: producer strobe side, consumer
// valid/ready side, and overflow status/control.
interface example2_capture_fifo_if #(
    parameter int DATA_W = 17,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_ready;
    logic              clr_ovf;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic              out_parity;

    modport master (
        output in_valid, in_data, in_tag, out_ready, clr_ovf,
        input  in_ready, out_valid, out_data, out_tag,
        input  count, overflow, drop_count, out_parity
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready, clr_ovf,
        output in_ready, out_valid, out_data, out_tag,
        output count, overflow, drop_count, out_parity
    );
endinterface

// File: rtl/example2_capture_fifo.sv
// Capture stage after example2 decode: FWFT FIFO with overflow tracking.
// Optional per-entry parity bit: define EXAMPLE2_CAPTURE_PARITY_EN.
module example2_capture_fifo #(
    parameter int DATA_W = 17,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input logic clk,
    input logic rst,
    example2_capture_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = DATA_W + TAG_W;
`ifdef EXAMPLE2_CAPTURE_PARITY_EN
    localparam int EW = PW + 1;
`else
    localparam int EW = PW;
`endif

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_drop      = bus.in_valid & ~w_in_ready;
    assign w_head      = r_mem[r_rd_ptr];

`ifdef EXAMPLE2_CAPTURE_PARITY_EN
    assign w_entry        = {^{bus.in_data, bus.in_tag}, bus.in_data, bus.in_tag};
    assign bus.out_parity = w_out_valid & w_head[EW-1];
`else
    assign w_entry        = {bus.in_data, bus.in_tag};
    assign bus.out_parity = 1'b0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_valid ? w_head[PW-1:TAG_W] : '0;
    assign bus.out_tag    = w_out_valid ? w_head[TAG_W-1:0] : '0;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;

    // Storage write; contents are don't-care until counted valid, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers and occupancy; count alone decides full/empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop accounting; a drop in the clearing cycle restarts the count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_ovf) begin
                r_drop_count <= DROP_W'(1);
            end else if (~&r_drop_count) begin
                r_drop_count <= r_drop_count + DROP_W'(1);
            end
        end else if (bus.clr_ovf) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_example2_capture_fifo.sv
// Directed self-checking bench for example2_capture_fifo.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_example2_capture_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    example2_capture_fifo_if #(.DATA_W(17), .TAG_W(4), .DEPTH(4), .DROP_W(8)) bus ();

    example2_capture_fifo #(.DATA_W(17), .TAG_W(4), .DEPTH(4), .DROP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b1;
        tick();
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", bus.count);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs got v=%b r=%b want v=0 r=1",
                     bus.out_valid, bus.in_ready);
        end
        n_tests++;
        if (bus.out_data !== 17'h0 || bus.out_tag !== 4'h0 || bus.out_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got d=%h t=%h p=%b want 0",
                     bus.out_data, bus.out_tag, bus.out_parity);
        end
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ovf got o=%b d=%0d want 0/0",
                     bus.overflow, bus.drop_count);
        end
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_data  = 17'h1A5A5;
        bus.in_tag   = 4'h9;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_valid got v=%b c=%0d want v=1 c=1",
                     bus.out_valid, bus.count);
        end
        n_tests++;
        if (bus.out_data !== 17'h1A5A5 || bus.out_tag !== 4'h9) begin
            n_fail++;
            $display("FAIL single_data got %h/%h want 1a5a5/9",
                     bus.out_data, bus.out_tag);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 17'h0) begin
            n_fail++;
            $display("FAIL single_pop got c=%0d v=%b d=%h want 0/0/0",
                     bus.count, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 17'(i);
            bus.in_tag   = 4'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full got c=%0d r=%b want 4/0",
                     bus.count, bus.in_ready);
        end
        n_tests++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd2) begin
            n_fail++;
            $display("FAIL fill_drop got o=%b d=%0d want 1/2",
                     bus.overflow, bus.drop_count);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 17'(i) || bus.out_tag !== 4'(i)) begin
                n_fail++;
                $display("FAIL fill_drain%0d got v=%b d=%h t=%h want 1/%h/%h",
                         i, bus.out_valid, bus.out_data, bus.out_tag, i, i);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.count !== 3'd0 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_empty got c=%0d o=%b want 0/1",
                     bus.count, bus.overflow);
        end
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL fill_clr got o=%b d=%0d want 0/0",
                     bus.overflow, bus.drop_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 17'(100 + i);
            bus.in_tag   = 4'(i);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 17'(102 + i);
            bus.in_tag  = 4'(i + 2);
            n_tests++;
            if (bus.out_data !== 17'(100 + i) || bus.out_tag !== 4'(i)) begin
                n_fail++;
                $display("FAIL b2b_head%0d got %h/%h want %h/%h",
                         i, bus.out_data, bus.out_tag, 100 + i, i);
            end
            tick();
            n_tests++;
            if (bus.count !== 3'd2) begin
                n_fail++;
                $display("FAIL b2b_count%0d got %0d want 2", i, bus.count);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            n_tests++;
            if (bus.out_data !== 17'(100 + i)) begin
                n_fail++;
                $display("FAIL b2b_tail%0d got %h want %h",
                         i, bus.out_data, 100 + i);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.count !== 3'd0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got c=%0d o=%b want 0/0",
                     bus.count, bus.overflow);
        end
    endtask

    task automatic test_saturation();
        bus.in_valid = 1'b1;
        bus.in_data  = 17'h0AAAA;
        repeat (4) tick();
        repeat (300) tick();
        n_tests++;
        if (bus.drop_count !== 8'd255 || bus.count !== 3'd4) begin
            n_fail++;
            $display("FAIL sat_hold got d=%0d c=%0d want 255/4",
                     bus.drop_count, bus.count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.count !== 3'd3 || bus.drop_count !== 8'd255 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_fullpop got c=%0d d=%0d o=%b want 3/255/1",
                     bus.count, bus.drop_count, bus.overflow);
        end
        tick();
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        n_tests++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin
            n_fail++;
            $display("FAIL sat_clrdrop got o=%b d=%0d want 1/1",
                     bus.overflow, bus.drop_count);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 17'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.count !== 3'd3) begin
            n_fail++; $display("FAIL mid_pre got %0d want 3", bus.count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.out_data !== 17'h0) begin
            n_fail++;
            $display("FAIL mid_async got v=%b c=%0d d=%h want 0/0/0",
                     bus.out_valid, bus.count, bus.out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 17'h00042;
        bus.in_tag   = 4'h3;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 17'h00042 || bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_after got v=%b d=%h c=%0d want 1/00042/1",
                     bus.out_valid, bus.out_data, bus.count);
        end
        drain();
    endtask

    task automatic test_parity();
        logic exp0;
        logic exp1;
`ifdef EXAMPLE2_CAPTURE_PARITY_EN
        exp0 = 1'b0;
        exp1 = 1'b1;
`else
        exp0 = 1'b0;
        exp1 = 1'b0;
`endif
        bus.in_valid = 1'b1;
        bus.in_data  = 17'h00007;
        bus.in_tag   = 4'h1;
        tick();
        bus.in_data  = 17'h00001;
        bus.in_tag   = 4'h0;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_parity !== exp0 || bus.out_data !== 17'h00007) begin
            n_fail++;
            $display("FAIL par_first got p=%b d=%h want %b/00007",
                     bus.out_parity, bus.out_data, exp0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_parity !== exp1 || bus.out_data !== 17'h00001) begin
            n_fail++;
            $display("FAIL par_second got p=%b d=%h want %b/00001",
                     bus.out_parity, bus.out_data, exp1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_parity !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL par_empty got p=%b v=%b want 0/0",
                     bus.out_parity, bus.out_valid);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/example2_capture_fifo.md
Name: example2_capture_fifo

Overview:
- Registered capture stage directly downstream of the example2 decode logic.
- Samples the 17-bit muxed data bus (po05..po21) and a 4-bit strobe tag (po62..po65) when a capture strobe is asserted.
- Buffers each captured word/tag pair in a small first-word-fall-through FIFO with a valid/ready handshake towards the consumer.
- Tracks overflow (sticky flag plus saturating drop counter), because the upstream logic is combinational and cannot be back-pressured.

Parameters:
- DATA_W, 17, width of the captured data word.
- TAG_W, 4, width of the captured tag.
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  capture strobe from upstream.
- in_data  input  DATA_W  data bus to capture.
- in_tag  input  TAG_W  tag bits to capture.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  head entry is valid.
- out_data  output  DATA_W  head entry data.
- out_tag  output  TAG_W  head entry tag.
- out_ready  input  1  consumer accepts the head entry.
- clr_ovf  input  1  synchronous clear of overflow and drop_count.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a strobe is dropped.
- drop_count  output  DROP_W  number of dropped strobes, saturating.
- out_parity  output  1  parity of the head entry (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_count=0. Outputs go to out_valid=0, in_ready=1, out_data=0, out_tag=0, out_parity=0. Storage array is not reset.
- in_ready = (count != DEPTH). Combinational from count only; no dependency on out_ready, so there is no pass-through when full.
- push = in_valid & in_ready: write {in_data, in_tag} to mem[wr_ptr], then wr_ptr++ (wraps modulo DEPTH).
- pop = out_valid & out_ready: rd_ptr++ (wraps modulo DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
- FWFT timing:
  - out_valid = (count != 0).
  - out_data/out_tag = mem[rd_ptr] when out_valid, else forced to 0.
  - A word pushed at edge N is visible at the outputs immediately after edge N. Latency is 1 cycle from strobe to out_valid.
- Empty with push&pop requested: pop cannot occur (out_valid=0); push proceeds, count goes 0→1.
- Full with in_valid=1 and out_ready=1 in the same cycle:
  - in_ready=0, so the word is dropped even though a pop happens.
  - overflow is set and drop_count increments; count goes DEPTH→DEPTH-1.
- Drop accounting:
  - Every cycle with in_valid & ~in_ready sets overflow=1 and increments drop_count.
  - drop_count saturates at 2^DROP_W-1 and does not wrap.
- clr_ovf=1 clears overflow and drop_count at the next edge. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- Reset asserted mid-operation: all queued entries are discarded immediately (count=0, out_valid=0). No partial push completes.
- No internal state machine beyond pointers/count. count is authoritative for full/empty; pointer equality is not used.

Optional Feature:
- Macro: EXAMPLE2_CAPTURE_PARITY_EN.
- Defined:
  - Each entry stores one extra bit, the even parity (XOR reduction) of {in_data, in_tag} computed at push.
  - out_parity = stored bit of the head entry when out_valid, else 0.
  - Storage width is DATA_W+TAG_W+1.
- Undefined: no parity storage; out_parity tied to 0. Port list is unchanged.

Test Plan:
- Reset then idle: rst pulse, no strobes → count=0, out_valid=0, in_ready=1, out_data=0, overflow=0, drop_count=0.
- Single capture: in_valid=1 for one cycle, in_data=17'h1A5A5, in_tag=4'h9, out_ready=0 → next cycle out_valid=1, out_data=17'h1A5A5, out_tag=4'h9, count=1. Then out_ready=1 for one cycle → count=0, out_valid=0.
- Fill and overflow: 6 consecutive strobes with data 1..6, out_ready=0 → count=4, in_ready=0, overflow=1, drop_count=2. Draining yields 1,2,3,4 in order. clr_ovf=1 → overflow=0, drop_count=0.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data → count stays 2. Output order is strictly FIFO across pointer wrap.
- Saturation: keep FIFO full with in_valid=1 for 300 cycles → drop_count=255 and holds.
- Mid-operation reset: count=3, assert rst asynchronously between edges → out_valid=0 and count=0 immediately. After release, first new strobe 17'h00042 appears at head.
- Parity (with EXAMPLE2_CAPTURE_PARITY_EN): push data=17'h00007, tag=4'h1 → out_parity=0. Push data=17'h00001, tag=4'h0 → out_parity=1 when that entry reaches the head. Without the macro, out_parity=0 in both cases.
